ov7670_stream_gen: RTL and testbench
====================================

# ov7670_stream_gen

Synthesizable OV7670-compatible pixel-bus transmitter. It drives pclk, vsync, href and an 8-bit data bus in RGB444 two-bytes-per-pixel format, so the camera-side capture path can be exercised without a sensor. The block sits in place of the camera pins, feeds the existing capture module on the board, and serves as the stimulus source in simulation. Frame geometry is parameterised, and the pattern is selectable per frame.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, byte slots with href low at the end of each line.
- VSYNC_LINES, 3, lines with vsync high.
- V_BACK, 17, blank lines after vsync.
- V_FRONT, 10, blank lines after the last active line.

Ports:
- clk  in  1  system clock (50 MHz on the board).
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  level; frames are emitted while it is high.
- mode  in  2  pattern select: 0 colour bars, 1 ramp, 2 checker, 3 solid.
- solid_rgb  in  12  {R,G,B} 4 bits each, used in mode 3.
- pclk  out  1  pixel clock, clk/2.
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, active high.
- d  out  8  pixel byte.
- busy  out  1  high from frame start until frame end.
- frame_done  out  1  one-clk pulse at the end of each frame.
- frame_sum  out  16  checksum; only meaningful with the macro (see Configuration).

## Operation
- Reset values: pclk=0, vsync=0, href=0, d=0, busy=0, frame_done=0, frame_sum=0, state=IDLE.
- pclk toggles every clk from the first cycle after reset.
- Slot step: all state, counters and outputs other than pclk update only on cycles where pclk is currently 1, i.e. at pclk falling edges. One slot = 2 clk.
- Line = 2*H_ACTIVE + H_BLANK slots. Slot counter x runs 0..line-1 and wraps.
- State machine:
  - IDLE → VSYNC at a slot step when enable=1. mode and solid_rgb are latched here and held for the whole frame.
  - VSYNC (VSYNC_LINES lines, vsync=1) → VBACK (V_BACK lines) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines).
  - Leaving VFRONT: frame_done pulses for one clk. Then go to VSYNC if enable=1, else to IDLE.
  - If enable drops mid-frame, the current frame completes; there is no truncation.
- ACTIVE lines:
  - href=1 for x < 2*H_ACTIVE, otherwise href=0 and d=0.
  - Pixel index p = x>>1. Even x outputs {4'h0, R}; odd x outputs {G, B}.
- d=0 whenever href=0.
- Patterns, with y = active line index:
  - Mode 0: 8 bars, each H_ACTIVE/8 wide: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Mode 1: R=G=B=p[3:0].
  - Mode 2: FFF if p[3]^y[3], else 000.
  - Mode 3: the latched solid_rgb.
- busy=1 from the VSYNC entry step until the step that leaves VFRONT.

## Timing
- Outputs are registered. d, href and vsync change in the same clk that pclk goes 1→0, so they are stable for 2 clk around each pclk rising edge.
- Latency: enable high in IDLE → vsync=1 at the next slot step, within 1–2 clk.
- Frame length: (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) × line × 2 clk.
- Reset low in any state: all outputs take their reset values on the next clk edge, and the frame is abandoned.

## Configuration
- OV_STREAM_GEN_CHECKSUM_EN defined:
  - frame_sum accumulates the 16-bit wrapping sum of every d byte sent with href=1.
  - The sum clears at VSYNC entry.
  - It updates to the final value at the step that pulses frame_done and holds until the next frame completes.
- Not defined: frame_sum is tied to 0 and no accumulator is built.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (20 slots/line, 200 clk/frame).
- Reset then enable=1, mode=3, solid_rgb=12'hA5C → 2 lines of 8 pixels, bytes alternating 0x0A, 0x5C. href high for 16 consecutive slots per line, 4 slots low between. vsync high for 40 clk.
- mode=0, one frame → bar 0 bytes are 0x0F, 0xFF and bar 5 bytes are 0x0F, 0x00 (one pixel per bar). frame_done pulses exactly once, 200 clk after vsync rises.
- Drop enable at clk 60 of a frame → frame completes normally, busy falls with frame_done, no second vsync.
- Change mode 3→1 mid-frame → the rest of the frame is still solid; the next frame is a ramp with pixel 5 = bytes 0x05, 0x55.
- Assert reset_n=0 during an ACTIVE line → next clk pclk=0, href=0, d=0, busy=0. After release the next frame starts with a full vsync.
- With OV_STREAM_GEN_CHECKSUM_EN, mode=3, solid_rgb=12'h123 → frame_sum = 16 × (0x01 + 0x23) = 0x0240. Without the macro, frame_sum stays 0.

Source files
------------

// File: rtl/ov7670_stream_gen.sv
// OV7670-compatible pixel-bus transmitter (RGB444, two bytes per pixel).
// Drives pclk/vsync/href/d in place of the camera pins. Frame geometry is set by
// parameters, and the test pattern is latched at the start of every frame.
// Optional build macro OV_STREAM_GEN_CHECKSUM_EN adds a per-frame byte checksum on frame_sum.
module ov7670_stream_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [11:0] solid_rgb,
   output logic        pclk,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_sum
);

   localparam int LINE  = 2*H_ACTIVE + H_BLANK;
   localparam int XW    = $clog2(LINE);
   localparam int BAR_W = H_ACTIVE / 8;

   localparam logic [XW-1:0] X_LAST   = XW'(LINE - 1);
   localparam logic [XW-1:0] HREF_END = XW'(2*H_ACTIVE);

   localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_LINES - 1);
   localparam logic [15:0] BACK_LAST   = 16'(V_BACK - 1);
   localparam logic [15:0] ACTIVE_LAST = 16'(V_ACTIVE - 1);
   localparam logic [15:0] FRONT_LAST  = 16'(V_FRONT - 1);

   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

   state_t         state;
   state_t         nxt_state;
   logic [XW-1:0]  x;
   logic [XW-1:0]  nxt_x;
   logic [15:0]    row;
   logic [15:0]    nxt_row;
   logic [15:0]    row_last;
   logic           frame_end;
   logic           vs_entry;
   logic [1:0]     mode_q;
   logic [11:0]    rgb_q;
   logic [15:0]    pix;
   logic [2:0]     bar;
   logic [11:0]    colour;
   logic [7:0]     pixel_byte;
   logic           active_href;

   // Number of the last line in whichever vertical region the frame is currently in.
   always_comb begin
      row_last = FRONT_LAST;
      case (state)
         VSYNC:   row_last = VSYNC_LAST;
         VBACK:   row_last = BACK_LAST;
         ACTIVE:  row_last = ACTIVE_LAST;
         default: row_last = FRONT_LAST;
      endcase
   end

   // Position of the next slot: slot counter, line-within-region counter and region.
   always_comb begin
      nxt_state = state;
      nxt_x     = x;
      nxt_row   = row;
      frame_end = 1'b0;
      vs_entry  = 1'b0;
      if (state == IDLE) begin
         if (enable) begin
            nxt_state = VSYNC;
            nxt_x     = '0;
            nxt_row   = '0;
            vs_entry  = 1'b1;
         end
      end else if (x == X_LAST) begin
         nxt_x = '0;
         if (row == row_last) begin
            nxt_row = '0;
            case (state)
               VSYNC:  nxt_state = VBACK;
               VBACK:  nxt_state = ACTIVE;
               ACTIVE: nxt_state = VFRONT;
               default: begin
                  frame_end = 1'b1;
                  if (enable) begin
                     nxt_state = VSYNC;
                     vs_entry  = 1'b1;
                  end else begin
                     nxt_state = IDLE;
                  end
               end
            endcase
         end else begin
            nxt_row = row + 16'd1;
         end
      end else begin
         nxt_x = x + XW'(1);
      end
   end

   // Pattern colour and byte for the next slot, from the frame's latched mode.
   always_comb begin
      pix    = 16'(nxt_x >> 1);
      bar    = 3'(pix / 16'(BAR_W));
      colour = 12'h000;
      case (mode_q)
         2'd0: begin
            case (bar)
               3'd0:    colour = 12'hFFF;
               3'd1:    colour = 12'hFF0;
               3'd2:    colour = 12'h0FF;
               3'd3:    colour = 12'h0F0;
               3'd4:    colour = 12'hF0F;
               3'd5:    colour = 12'hF00;
               3'd6:    colour = 12'h00F;
               default: colour = 12'h000;
            endcase
         end
         2'd1:    colour = {3{pix[3:0]}};
         2'd2:    colour = (pix[3] ^ nxt_row[3]) ? 12'hFFF : 12'h000;
         default: colour = rgb_q;
      endcase
      pixel_byte  = nxt_x[0] ? colour[7:0] : {4'h0, colour[11:8]};
      active_href = (nxt_state == ACTIVE) && (nxt_x < HREF_END);
   end

   // Frame state machine; everything except pclk advances on pclk falling edges.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pclk       <= 1'b0;
         state      <= IDLE;
         x          <= '0;
         row        <= '0;
         vsync      <= 1'b0;
         href       <= 1'b0;
         d          <= 8'h00;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         mode_q     <= 2'd0;
         rgb_q      <= 12'h000;
      end else begin
         pclk       <= ~pclk;
         frame_done <= 1'b0;
         if (pclk) begin
            state      <= nxt_state;
            x          <= nxt_x;
            row        <= nxt_row;
            vsync      <= (nxt_state == VSYNC);
            href       <= active_href;
            d          <= active_href ? pixel_byte : 8'h00;
            busy       <= (nxt_state != IDLE);
            frame_done <= frame_end;
            if (vs_entry) begin
               mode_q <= mode;
               rgb_q  <= solid_rgb;
            end
         end
      end
   end

`ifdef OV_STREAM_GEN_CHECKSUM_EN
   logic [15:0] sum_acc;

   // Running sum of bytes sent with href high; published when the frame ends.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum_acc   <= 16'h0000;
         frame_sum <= 16'h0000;
      end else if (pclk) begin
         if (frame_end) begin
            frame_sum <= sum_acc;
         end
         if (vs_entry) begin
            sum_acc <= 16'h0000;
         end else if (href) begin
            sum_acc <= sum_acc + {8'h00, d};
         end
      end
   end
`else
   assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen using a small frame geometry.
// Expected bus contents come from a slot-indexed model of the frame layout.
module tb_ov7670_stream_gen;

   localparam int H_ACTIVE    = 8;
   localparam int V_ACTIVE    = 2;
   localparam int H_BLANK     = 4;
   localparam int VSYNC_LINES = 1;
   localparam int V_BACK      = 1;
   localparam int V_FRONT     = 1;
   localparam int LINE        = 2*H_ACTIVE + H_BLANK;
   localparam int FRAME_SLOTS = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  mode;
   logic [11:0] solid_rgb;
   logic        pclk;
   logic        vsync;
   logic        href;
   logic [7:0]  d;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_sum;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [9:0]  obs [FRAME_SLOTS];
   logic        obs_pclk [FRAME_SLOTS];
   logic        obs_busy [FRAME_SLOTS];
   int          pulses;
   bit          cap_ok;
   logic        end_done;
   logic        end_busy;
   logic        end_vsync;
   logic [15:0] end_sum;

   ov7670_stream_gen #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
      .pclk(pclk), .vsync(vsync), .href(href), .d(d), .busy(busy),
      .frame_done(frame_done), .frame_sum(frame_sum)
   );

   always #5 clk = ~clk;

   // Pattern colour of pixel p on active line y.
   function automatic logic [11:0] model_colour(int m, int p, int y, logic [11:0] rgb);
      logic [11:0] c;
      c = 12'h000;
      case (m)
         0: begin
            case (p / (H_ACTIVE/8))
               0: c = 12'hFFF;
               1: c = 12'hFF0;
               2: c = 12'h0FF;
               3: c = 12'h0F0;
               4: c = 12'hF0F;
               5: c = 12'hF00;
               6: c = 12'h00F;
               default: c = 12'h000;
            endcase
         end
         1: c = {3{4'(p % 16)}};
         2: c = (((p/8) % 2) != ((y/8) % 2)) ? 12'hFFF : 12'h000;
         default: c = rgb;
      endcase
      return c;
   endfunction

   // Expected {vsync, href, d} for slot k of a frame.
   function automatic logic [9:0] model_slot(int k, int m, logic [11:0] rgb);
      int          line_no;
      int          x;
      logic [11:0] c;
      logic        vs;
      logic        hr;
      logic [7:0]  b;
      line_no = k / LINE;
      x       = k % LINE;
      vs      = (line_no < VSYNC_LINES);
      hr      = (line_no >= VSYNC_LINES + V_BACK) &&
                (line_no < VSYNC_LINES + V_BACK + V_ACTIVE) && (x < 2*H_ACTIVE);
      b       = 8'h00;
      if (hr) begin
         c = model_colour(m, x/2, line_no - VSYNC_LINES - V_BACK, rgb);
         b = (x % 2 == 0) ? {4'h0, c[11:8]} : c[7:0];
      end
      return {vs, hr, b};
   endfunction

   // Expected frame_sum after a frame with the given pattern.
   function automatic logic [15:0] model_sum(int m, logic [11:0] rgb);
      logic [15:0] s;
      logic [9:0]  e;
      s = 16'h0000;
`ifdef OV_STREAM_GEN_CHECKSUM_EN
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, m, rgb);
         if (e[8]) s = s + {8'h00, e[7:0]};
      end
`else
      e = model_slot(0, m, rgb);
      s = {6'd0, e} & 16'h0000;
`endif
      return s;
   endfunction

   // Waits for vsync, then records one full frame slot by slot plus the end-of-frame outputs.
   task automatic capture_frame();
      int guard;
      guard  = 0;
      cap_ok = 1'b1;
      pulses = 0;
      while (vsync !== 1'b1 && guard < 400) begin
         @(posedge clk); #1;
         guard++;
      end
      if (vsync !== 1'b1) begin
         cap_ok = 1'b0;
      end else begin
         for (int k = 0; k < FRAME_SLOTS; k++) begin
            obs[k]      = {vsync, href, d};
            obs_pclk[k] = pclk;
            obs_busy[k] = busy;
            repeat (2) begin
               @(posedge clk); #1;
               if (frame_done === 1'b1) pulses++;
            end
         end
         end_done  = frame_done;
         end_busy  = busy;
         end_vsync = vsync;
         end_sum   = frame_sum;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      tests_run++;
      if ({pclk, vsync, href, busy, frame_done, d, frame_sum} !== 29'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got pclk=%b vs=%b href=%b busy=%b done=%b d=%h sum=%h, want all 0",
                  pclk, vsync, href, busy, frame_done, d, frame_sum);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (pclk !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL pclk_first_toggle: got %b, want 1", pclk);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({pclk, busy, vsync} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL idle_after_reset: got pclk/busy/vs=%b%b%b, want 000", pclk, busy, vsync);
      end
   endtask

   task automatic test_solid();
      int lat;
      logic [9:0] e;
      mode      = 2'd3;
      solid_rgb = 12'hA5C;
      enable    = 1'b1;
      lat       = 0;
      while (vsync !== 1'b1 && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (lat < 1 || lat > 2) begin
         tests_failed++;
         $display("[TB] FAIL start_latency: got %0d clk, want 1..2", lat);
      end
      capture_frame();
      tests_run++;
      if (!cap_ok) begin
         tests_failed++;
         $display("[TB] FAIL solid_capture: got no vsync, want frame");
      end
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, 3, 12'hA5C);
         tests_run++;
         if (obs[k] !== e || obs_pclk[k] !== 1'b0 || obs_busy[k] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL solid_slot%0d: got vs/href/d=%h pclk=%b busy=%b, want %h pclk=0 busy=1",
                     k, obs[k], obs_pclk[k], obs_busy[k], e);
         end
      end
      tests_run++;
      if (pulses !== 1 || end_done !== 1'b1 || {end_busy, end_vsync} !== 2'b11) begin
         tests_failed++;
         $display("[TB] FAIL solid_frame_end: got pulses=%0d done=%b busy/vs=%b%b, want 1 1 11",
                  pulses, end_done, end_busy, end_vsync);
      end
      tests_run++;
      if (end_sum !== model_sum(3, 12'hA5C)) begin
         tests_failed++;
         $display("[TB] FAIL solid_sum: got %h, want %h", end_sum, model_sum(3, 12'hA5C));
      end
   endtask

   task automatic test_mode_change();
      logic [9:0]  e;
      logic [11:0] late_rgb;
      late_rgb = 12'($urandom);
      fork
         capture_frame();
         begin
            repeat (100) @(posedge clk);
            #1;
            mode      = 2'd1;
            solid_rgb = late_rgb;
         end
      join
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, 3, 12'hA5C);
         tests_run++;
         if (!cap_ok || obs[k] !== e) begin
            tests_failed++;
            $display("[TB] FAIL held_mode_slot%0d: got %h, want %h", k, obs[k], e);
         end
      end
      capture_frame();
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, 1, late_rgb);
         tests_run++;
         if (!cap_ok || obs[k] !== e) begin
            tests_failed++;
            $display("[TB] FAIL ramp_slot%0d: got %h, want %h", k, obs[k], e);
         end
      end
      tests_run++;
      if ({obs[2*LINE + 10][7:0], obs[2*LINE + 11][7:0]} !== 16'h0555) begin
         tests_failed++;
         $display("[TB] FAIL ramp_pixel5: got %h %h, want 05 55", obs[2*LINE + 10][7:0], obs[2*LINE + 11][7:0]);
      end
   endtask

   task automatic test_enable_drop();
      logic [9:0] e;
      int         extra_vs;
      fork
         capture_frame();
         begin
            repeat (60) @(posedge clk);
            #1;
            enable = 1'b0;
         end
      join
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, 1, 12'h000);
         tests_run++;
         if (!cap_ok || obs[k] !== e || obs_busy[k] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drop_slot%0d: got %h busy=%b, want %h busy=1", k, obs[k], obs_busy[k], e);
         end
      end
      tests_run++;
      if (pulses !== 1 || end_done !== 1'b1 || {end_busy, end_vsync} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL drop_frame_end: got pulses=%0d done=%b busy/vs=%b%b, want 1 1 00",
                  pulses, end_done, end_busy, end_vsync);
      end
      extra_vs = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (vsync !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) extra_vs++;
      end
      tests_run++;
      if (extra_vs !== 0) begin
         tests_failed++;
         $display("[TB] FAIL drop_no_restart: got %0d active clk, want 0", extra_vs);
      end
   endtask

   task automatic test_colour_bars();
      logic [9:0] e;
      mode   = 2'd0;
      enable = 1'b1;
      fork
         capture_frame();
         begin
            repeat (60) @(posedge clk);
            #1;
            enable = 1'b0;
         end
      join
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, 0, 12'h000);
         tests_run++;
         if (!cap_ok || obs[k] !== e) begin
            tests_failed++;
            $display("[TB] FAIL bars_slot%0d: got %h, want %h", k, obs[k], e);
         end
      end
      tests_run++;
      if ({obs[2*LINE][7:0], obs[2*LINE + 1][7:0]} !== 16'h0FFF) begin
         tests_failed++;
         $display("[TB] FAIL bar0_bytes: got %h %h, want 0F FF", obs[2*LINE][7:0], obs[2*LINE + 1][7:0]);
      end
      tests_run++;
      if ({obs[2*LINE + 10][7:0], obs[2*LINE + 11][7:0]} !== 16'h0F00) begin
         tests_failed++;
         $display("[TB] FAIL bar5_bytes: got %h %h, want 0F 00", obs[2*LINE + 10][7:0], obs[2*LINE + 11][7:0]);
      end
      tests_run++;
      if (pulses !== 1 || end_done !== 1'b1 || end_busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bars_frame_done: got pulses=%0d done=%b busy=%b, want 1 1 0", pulses, end_done, end_busy);
      end
   endtask

   task automatic test_checksum();
      logic [15:0] want;
`ifdef OV_STREAM_GEN_CHECKSUM_EN
      want = 16'h0240;
`else
      want = 16'h0000;
`endif
      mode      = 2'd3;
      solid_rgb = 12'h123;
      enable    = 1'b1;
      fork
         capture_frame();
         begin
            repeat (60) @(posedge clk);
            #1;
            enable = 1'b0;
         end
      join
      tests_run++;
      if (!cap_ok || end_sum !== want) begin
         tests_failed++;
         $display("[TB] FAIL checksum_123: got %h, want %h", end_sum, want);
      end
      repeat (20) begin @(posedge clk); #1; end
      tests_run++;
      if (frame_sum !== want) begin
         tests_failed++;
         $display("[TB] FAIL checksum_hold: got %h, want %h", frame_sum, want);
      end
   endtask

   task automatic test_back_to_back();
      int          cur_m;
      int          nxt_m;
      logic [11:0] cur_rgb;
      logic [11:0] nxt_rgb;
      logic [9:0]  e;
      cur_m     = int'($urandom_range(0, 3));
      cur_rgb   = 12'($urandom);
      mode      = 2'(cur_m);
      solid_rgb = cur_rgb;
      enable    = 1'b1;
      for (int n = 0; n < 5; n++) begin
         nxt_m   = int'($urandom_range(0, 3));
         nxt_rgb = 12'($urandom);
         fork
            capture_frame();
            begin
               repeat (100) @(posedge clk);
               #1;
               mode      = 2'(nxt_m);
               solid_rgb = nxt_rgb;
               if (n == 4) enable = 1'b0;
            end
         join
         for (int k = 0; k < FRAME_SLOTS; k++) begin
            e = model_slot(k, cur_m, cur_rgb);
            tests_run++;
            if (!cap_ok || obs[k] !== e) begin
               tests_failed++;
               $display("[TB] FAIL b2b%0d_mode%0d_slot%0d: got %h, want %h", n, cur_m, k, obs[k], e);
            end
         end
         tests_run++;
         if (pulses !== 1 || end_sum !== model_sum(cur_m, cur_rgb)) begin
            tests_failed++;
            $display("[TB] FAIL b2b%0d_end: got pulses=%0d sum=%h, want 1 %h",
                     n, pulses, end_sum, model_sum(cur_m, cur_rgb));
         end
         cur_m   = nxt_m;
         cur_rgb = nxt_rgb;
      end
   endtask

   task automatic test_reset_mid();
      int          m;
      int          guard;
      logic [11:0] rgb;
      logic [9:0]  e;
      m         = int'($urandom_range(0, 3));
      rgb       = 12'($urandom);
      mode      = 2'(m);
      solid_rgb = rgb;
      enable    = 1'b1;
      guard     = 0;
      while (vsync !== 1'b1 && guard < 400) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (100) begin @(posedge clk); #1; end
      e = model_slot(50, m, rgb);
      tests_run++;
      if ({vsync, href, d} !== e) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_active: got %h, want %h", {vsync, href, d}, e);
      end
      reset_n = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if ({pclk, vsync, href, busy, frame_done, d, frame_sum} !== 29'd0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_outputs: got pclk=%b vs=%b href=%b busy=%b d=%h sum=%h, want all 0",
                  pclk, vsync, href, busy, d, frame_sum);
      end
      reset_n = 1'b1;
      capture_frame();
      for (int k = 0; k < FRAME_SLOTS; k++) begin
         e = model_slot(k, m, rgb);
         tests_run++;
         if (!cap_ok || obs[k] !== e) begin
            tests_failed++;
            $display("[TB] FAIL restart_slot%0d: got %h, want %h", k, obs[k], e);
         end
      end
      tests_run++;
      if (pulses !== 1 || end_sum !== model_sum(m, rgb)) begin
         tests_failed++;
         $display("[TB] FAIL restart_end: got pulses=%0d sum=%h, want 1 %h", pulses, end_sum, model_sum(m, rgb));
      end
      enable = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      mode      = 2'd0;
      solid_rgb = 12'h000;
      test_reset();
      test_solid();
      test_mode_change();
      test_enable_drop();
      test_colour_bars();
      test_checksum();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no completion, want finish before 400000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
